// File: rtl/sd_defs.sv
// SD card SPI-mode shared definitions.
// Command opcodes, tokens and block geometry.
package sd_defs;

  localparam logic [7:0] CMD17       = 8'h51;
  localparam logic [7:0] CMD24       = 8'h58;
  localparam logic [7:0] HEAD_BYTE   = 8'hfe;
  localparam logic [7:0] R1_OK       = 8'h00;
  localparam int         BLOCK_BYTES = 512;

endpackage

// File: rtl/sd_rx_shift.sv
// MISO shift register, 8 or 16 bits per unit.
// Optional start-bit hunt for R1-style responses.
module sd_rx_shift (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        hunt_i,
  input  logic        len16_i,
  input  logic        miso_i,
  output logic        done_o,
  output logic [15:0] word_o
);

  logic [14:0] sh_q;
  logic [3:0]  cnt_q;
  logic        act_q;
  logic        take;
  logic [3:0]  last;

  assign take   = en_i & (act_q | ~hunt_i | ~miso_i);
  assign last   = len16_i ? 4'd15 : 4'd7;
  assign done_o = take & (cnt_q == last);
  assign word_o = {sh_q, miso_i};

  // Shift while enabled; in hunt mode wait for a 0 start bit
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      act_q <= 1'b0;
    end else if (take) begin
      sh_q <= {sh_q[13:0], miso_i};
      if (done_o) begin
        cnt_q <= '0;
        act_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
        act_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_read.sv
// SPI-mode SD single-block reader (CMD17).
// Streams one 512-byte sector as 16-bit words.
module sd_read
  import sd_defs::*;
#(
  parameter int WORD_NUM      = BLOCK_BYTES / 2,
  parameter int TOKEN_TIMEOUT = 50000,
  parameter int END_CLKS      = 8
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        sd_miso,
  output logic        sd_cs,
  output logic        sd_mosi,
  input  logic        rd_start_en,
  input  logic [31:0] rd_sec_addr,
  output logic        rd_busy,
  output logic        rd_val_en,
  output logic [15:0] rd_val_data,
  output logic        rd_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WAIT_R1, S_WAIT_TOK,
    S_DATA, S_CRC, S_END
  } state_e;

  state_e      state_q;
  logic [2:0]  sync_q;
  logic [47:0] cmd_q;
  logic [5:0]  cnt_q;
  logic [15:0] tmo_q;
  logic [8:0]  wcnt_q;
  logic [7:0]  tok_q;
  logic        cs_q, mosi_q, busy_q;
  logic        val_q, err_q;
  logic [15:0] data_q;

  logic        start_edge, tmo_hit;
  logic        rx_en, rx_hunt, rx_len16, rx_done;
  logic [15:0] rx_word;
  logic [7:0]  tok_d;
  logic [15:0] tmo_d;

  assign start_edge = sync_q[1] & ~sync_q[2];
  assign rx_en      = (state_q == S_WAIT_R1) | (state_q == S_DATA);
  assign rx_hunt    = (state_q == S_WAIT_R1);
  assign rx_len16   = (state_q == S_DATA);
  assign tmo_hit    = tmo_q >= 16'(TOKEN_TIMEOUT - 1);
  assign tok_d      = {tok_q[6:0], sd_miso};
  assign tmo_d      = (tmo_q == 16'hffff) ? tmo_q : tmo_q + 16'd1;

  assign sd_cs       = cs_q;
  assign sd_mosi     = mosi_q;
  assign rd_busy     = busy_q;
  assign rd_val_en   = val_q;
  assign rd_val_data = data_q;
  assign rd_err      = err_q;

  sd_rx_shift u_rx (
    .clk_i   (clk_ref),
    .rst_n   (rst_n),
    .en_i    (rx_en),
    .hunt_i  (rx_hunt),
    .len16_i (rx_len16),
    .miso_i  (sd_miso),
    .done_o  (rx_done),
    .word_o  (rx_word)
  );

  // Two-flop synchroniser plus edge history for the start request
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], rd_start_en};
  end

  // Read sequencer with registered pad and strobe outputs
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      wcnt_q  <= '0;
      tok_q   <= '0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b1;
      busy_q  <= 1'b0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      val_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cs_q   <= 1'b1;
          mosi_q <= 1'b1;
          if (start_edge) begin
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            mosi_q  <= CMD17[7];
            cmd_q   <= {CMD17[6:0], rd_sec_addr, 8'hff, 1'b1};
            cnt_q   <= 6'd47;
            state_q <= S_CMD;
          end
        end
        S_CMD: begin
          mosi_q <= cmd_q[47];
          cmd_q  <= {cmd_q[46:0], 1'b1};
          if (cnt_q == 6'd0) begin
            mosi_q  <= 1'b1;
            tmo_q   <= '0;
            state_q <= S_WAIT_R1;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        S_WAIT_R1: begin
          tmo_q <= tmo_d;
          if (rx_done) begin
            tmo_q <= '0;
            if (rx_word[7:0] == R1_OK) begin
              tok_q   <= '0;
              state_q <= S_WAIT_TOK;
            end else begin
              err_q   <= 1'b1;
              cs_q    <= 1'b1;
              cnt_q   <= 6'(END_CLKS - 1);
              state_q <= S_END;
            end
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            cs_q    <= 1'b1;
            cnt_q   <= 6'(END_CLKS - 1);
            state_q <= S_END;
          end
        end
        S_WAIT_TOK: begin
          tok_q <= tok_d;
          tmo_q <= tmo_d;
          if (!sd_miso && tok_d == HEAD_BYTE) begin
            tmo_q   <= '0;
            wcnt_q  <= '0;
            state_q <= S_DATA;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            cs_q    <= 1'b1;
            cnt_q   <= 6'(END_CLKS - 1);
            state_q <= S_END;
          end
        end
        S_DATA: begin
          if (rx_done) begin
            val_q  <= 1'b1;
            data_q <= rx_word;
            if (wcnt_q == 9'(WORD_NUM - 1)) begin
              cnt_q   <= 6'd15;
              state_q <= S_CRC;
            end else begin
              wcnt_q <= wcnt_q + 9'd1;
            end
          end
        end
        S_CRC: begin
          if (cnt_q == 6'd0) begin
            cs_q    <= 1'b1;
            cnt_q   <= 6'(END_CLKS - 1);
            state_q <= S_END;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        S_END: begin
          cs_q   <= 1'b1;
          mosi_q <= 1'b1;
          if (cnt_q == 6'd0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
